fabric_slice_cfg: RTL

FABRIC_SLICE_CFG -- requirements
Module: fabric_slice_cfg

---
 rtl/fabric_slice_cfg.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fabric_slice_cfg.sv
// ---------------------------------------------------------------------------
// fabric_slice_cfg
//   A slice of NUM_FLE logic lanes loaded through a serial configuration
//   chain. Each lane has a LUT_K-input LUT (or a full-adder bit in carry
//   mode), one flip-flop and an output select. A small FSM counts shifted
//   bits. It raises cfg_valid once a complete configuration is in place and
//   drops it as soon as the chain is disturbed again.
//
//   Optional feature macro: FABRIC_SLICE_SCAN_EN
//     defined   -> Test_en turns the lane FFs into a scan chain
//                  (fabric_sc_in -> lane 0 -> ... -> fabric_sc_out).
//     undefined -> Test_en and fabric_sc_in are ignored.
//
//   Ports
//     fabric_clk      in   clock (all state on rising edge)
//     fabric_reset    in   synchronous active-high reset
//     Test_en         in   scan mode select
//     ccff_en         in   config shift enable
//     ccff_head       in   serial config bit in
//     fabric_in       in   LUT inputs, lane j uses [j*LUT_K +: LUT_K]
//     fabric_reg_in   in   register-chain input to lane 0
//     fabric_sc_in    in   scan-chain input to lane 0
//     fabric_cin      in   carry into lane 0
//     fabric_out      out  per-lane selected output
//     fabric_reg_out  out  Q of last lane
//     fabric_sc_out   out  Q of last lane
//     fabric_cout     out  carry out of last lane
//     ccff_tail       out  last config chain bit
//     cfg_valid       out  full configuration loaded
//
//   Lane j config field at [j*CFG_W +: CFG_W]:
//     [0 .. 2^LUT_K-1] truth table, then d_sel, out_sel, carry_mode.
// ---------------------------------------------------------------------------
module fabric_slice_cfg #(
    parameter int NUM_FLE = 2,
    parameter int LUT_K   = 4
) (
    input  logic                       fabric_clk,
    input  logic                       fabric_reset,
    input  logic                       Test_en,
    input  logic                       ccff_en,
    input  logic                       ccff_head,
    input  logic [NUM_FLE*LUT_K-1:0]   fabric_in,
    input  logic                       fabric_reg_in,
    input  logic                       fabric_sc_in,
    input  logic                       fabric_cin,
    output logic [NUM_FLE-1:0]         fabric_out,
    output logic                       fabric_reg_out,
    output logic                       fabric_sc_out,
    output logic                       fabric_cout,
    output logic                       ccff_tail,
    output logic                       cfg_valid
);

    localparam int LUT_N     = 1 << LUT_K;
    localparam int CFG_W     = LUT_N + 3;
    localparam int CFG_BITS  = NUM_FLE * CFG_W;
    localparam int CNT_W     = $clog2(CFG_BITS + 1);
    localparam int OFF_DSEL  = LUT_N;
    localparam int OFF_OSEL  = LUT_N + 1;
    localparam int OFF_CMODE = LUT_N + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOCKED
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [CFG_BITS-1:0] r_cfg;
    logic [NUM_FLE-1:0]  r_q;
    logic                r_cfg_valid;
    logic [CNT_W-1:0]    r_cnt;
    state_t              r_state;

    logic [NUM_FLE-1:0]  w_lut_out;
    logic [NUM_FLE-1:0]  w_sel_out;
    logic [NUM_FLE-1:0]  w_norm_d;
    logic [NUM_FLE-1:0]  w_prev_q;
    logic [NUM_FLE-1:0]  w_ff_d;
    logic                w_ff_en;
    logic                w_carry_out;

    // Previous-lane Q seen by each lane; lane 0 takes the external input.
    assign w_prev_q = NUM_FLE'({r_q, fabric_reg_in});

    always_comb begin : lane_logic
        logic                v_carry;
        logic [LUT_N-1:0]    v_lut;
        logic [LUT_K-1:0]    v_in;
        logic                v_dsel;
        logic                v_osel;
        logic                v_cmode;
        v_carry   = fabric_cin;
        v_lut     = '0;
        v_in      = '0;
        v_dsel    = 1'b0;
        v_osel    = 1'b0;
        v_cmode   = 1'b0;
        w_lut_out = '0;
        w_sel_out = '0;
        w_norm_d  = '0;
        for (int j = 0; j < NUM_FLE; j++) begin
            v_lut   = r_cfg[j*CFG_W +: LUT_N];
            v_in    = fabric_in[j*LUT_K +: LUT_K];
            v_dsel  = r_cfg[j*CFG_W + OFF_DSEL];
            v_osel  = r_cfg[j*CFG_W + OFF_OSEL];
            v_cmode = r_cfg[j*CFG_W + OFF_CMODE];
            if (v_cmode) begin
                w_lut_out[j] = v_in[0] ^ v_in[1] ^ v_carry;
                v_carry      = maj3(v_in[0], v_in[1], v_carry);
            end else begin
                w_lut_out[j] = v_lut[v_in];
                // A non-carry lane breaks the chain for all lanes above it.
                v_carry      = 1'b0;
            end
            w_sel_out[j] = v_osel ? r_q[j] : w_lut_out[j];
            w_norm_d[j]  = v_dsel ? w_prev_q[j] : w_lut_out[j];
        end
        w_carry_out = v_carry;
    end

`ifdef FABRIC_SLICE_SCAN_EN
    logic [NUM_FLE-1:0] w_scan_d;
    assign w_scan_d = NUM_FLE'({r_q, fabric_sc_in});
    // Scan shifts regardless of configuration state.
    assign w_ff_en  = r_cfg_valid | Test_en;
    assign w_ff_d   = Test_en ? w_scan_d : w_norm_d;
`else
    logic w_unused;
    assign w_unused = Test_en ^ fabric_sc_in;
    assign w_ff_en  = r_cfg_valid;
    assign w_ff_d   = w_norm_d;
`endif

    // Config chain, lane FFs and load-tracking FSM
    always_ff @(posedge fabric_clk) begin
        if (fabric_reset) begin
            r_cfg       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_cfg_valid <= 1'b0;
            r_state     <= S_IDLE;
        end else begin
            if (ccff_en) begin
                r_cfg <= {r_cfg[CFG_BITS-2:0], ccff_head};
            end
            // FFs sample with the configuration present before this edge.
            if (w_ff_en) begin
                r_q <= w_ff_d;
            end
            case (r_state)
                S_IDLE: begin
                    if (ccff_en) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ccff_en) begin
                        if (r_cnt == CNT_W'(CFG_BITS - 1)) begin
                            r_cnt       <= CNT_W'(CFG_BITS);
                            r_cfg_valid <= 1'b1;
                            r_state     <= S_LOCKED;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOCKED: begin
                    // Any extra bit invalidates the load and starts a new one.
                    if (ccff_en) begin
                        r_cnt       <= CNT_W'(1);
                        r_cfg_valid <= 1'b0;
                        r_state     <= S_SHIFT;
                    end
                end
                default: begin
                    r_cnt       <= '0;
                    r_cfg_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign fabric_out     = r_cfg_valid ? w_sel_out : '0;
    assign fabric_cout    = r_cfg_valid & w_carry_out;
    assign fabric_reg_out = r_q[NUM_FLE-1];
    assign fabric_sc_out  = r_q[NUM_FLE-1];
    assign ccff_tail      = r_cfg[CFG_BITS-1];
    assign cfg_valid      = r_cfg_valid;

endmodule
